// File: rtl/notch2_pkg.sv
// Shared widths, state/coefficient enums and the round/reduce helper for the notch2 biquad.
// Optional feature macro: NOTCH2_SATURATE_EN (clamp on overflow instead of wrapping).
package notch2_pkg;

    localparam int unsigned DW = 16;  // sample width
    localparam int unsigned CW = 16;  // coefficient width
    localparam int unsigned CF = 14;  // coefficient fraction bits (Q2.14)
    localparam int unsigned AW = 40;  // accumulator width, >= DW+CW+3

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StRnd,
        StOut
    } state_e;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_e;

    typedef struct packed {
        logic [DW-1:0] val;
`ifdef NOTCH2_SATURATE_EN
        logic          sat;
`endif
    } rnd_t;

    // Half an LSB of the output, added before the fraction bits are dropped
    localparam logic [AW-1:0] RndHalf = {{(AW-CF){1'b0}}, 1'b1, {(CF-1){1'b0}}};
    localparam logic signed [AW-1:0] YMax = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMin = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Round to nearest (ties toward +inf), drop CF fraction bits, then clamp or wrap to DW
    function automatic rnd_t rnd_reduce(input logic [AW-1:0] acc);
        logic signed [AW-1:0] shifted;
        rnd_t                 res;
        shifted = $signed(acc + RndHalf) >>> CF;
`ifdef NOTCH2_SATURATE_EN
        res.sat = 1'b1;
        if (shifted > YMax) begin
            res.val = {1'b0, {(DW-1){1'b1}}};
        end else if (shifted < YMin) begin
            res.val = {1'b1, {(DW-1){1'b0}}};
        end else begin
            res.val = DW'(shifted);
            res.sat = 1'b0;
        end
`else
        res.val = DW'(shifted);
`endif
        return res;
    endfunction

endpackage

// File: rtl/notch2_mac.sv
// Single time-multiplexed signed multiplier feeding a registered AW-bit accumulator.
// The sample operand is one bit wider than DW so that negated history (-y) never overflows.
module notch2_mac
    import notch2_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] coef,
    input  logic [DW:0]   sample,
    output logic [AW-1:0] acc
);

    logic signed [CW+DW:0] prod;
    logic [AW-1:0]         acc_q;

    assign prod = $signed(coef) * $signed(sample);
    assign acc  = acc_q;

    // Accumulate one full-precision, sign-extended product per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + {{(AW-CW-DW-1){prod[CW+DW]}}, prod};
        end
    end

endmodule

// File: rtl/notch2_biquad_iir.sv
// Direct-form-I biquad notch: y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2, one sample per 8 cycles.
// Optional feature macro: NOTCH2_SATURATE_EN (adds sat_flag output and output clamping).
module notch2_biquad_iir
    import notch2_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          coef_we,
    input  logic [2:0]    coef_addr,
    input  logic [CW-1:0] coef_wdata,
    input  logic          flush,
`ifdef NOTCH2_SATURATE_EN
    output logic          sat_flag,
`endif
    output logic          busy
);

    state_e        state_q, state_d;
    logic [2:0]    tap_q, tap_d;
    logic [DW-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic [DW-1:0] y1_q, y1_d, y2_q, y2_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
    logic          accept, coef_wr;
    logic          mac_en;
    logic [CW-1:0] mac_coef;
    logic [DW:0]   mac_sample;
    logic [AW-1:0] mac_acc;
    rnd_t          rnd;
`ifdef NOTCH2_SATURATE_EN
    logic          sat_q, sat_d;
    assign sat_flag = sat_q;
`endif

    // flush wins over an incoming sample, so the handshake is withheld while it is high
    assign in_ready  = (state_q == StIdle) && !flush;
    assign accept    = in_ready && in_valid;
    assign out_valid = (state_q == StOut) && !flush;
    assign busy      = (state_q != StIdle);
    assign out_data  = out_data_q;
    assign coef_wr   = coef_we && (state_q == StIdle);
    assign mac_en    = (state_q == StMac);
    assign rnd       = rnd_reduce(mac_acc);

    notch2_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     (mac_en),
        .coef   (mac_coef),
        .sample (mac_sample),
        .acc    (mac_acc)
    );

    // Select coefficient/sample pair for the current tap; feedback taps use negated history
    always_comb begin
        mac_coef   = '0;
        mac_sample = '0;
        unique case (tap_q)
            3'd0: begin
                mac_coef   = b0_q;
                mac_sample = {x0_q[DW-1], x0_q};
            end
            3'd1: begin
                mac_coef   = b1_q;
                mac_sample = {x1_q[DW-1], x1_q};
            end
            3'd2: begin
                mac_coef   = b2_q;
                mac_sample = {x2_q[DW-1], x2_q};
            end
            3'd3: begin
                mac_coef   = a1_q;
                mac_sample = -{y1_q[DW-1], y1_q};
            end
            3'd4: begin
                mac_coef   = a2_q;
                mac_sample = -{y2_q[DW-1], y2_q};
            end
            default: begin
                mac_coef   = '0;
                mac_sample = '0;
            end
        endcase
    end

    // FSM next state, history shift on RND, and flush abort
    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        out_data_d = out_data_q;
`ifdef NOTCH2_SATURATE_EN
        sat_d      = sat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    x0_d    = in_data;
                    tap_d   = 3'd0;
                    state_d = StMac;
                end
            end
            StMac: begin
                if (tap_q == 3'd4) begin
                    state_d = StRnd;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            StRnd: begin
                out_data_d = rnd.val;
                x2_d       = x1_q;
                x1_d       = x0_q;
                y2_d       = y1_q;
                y1_d       = rnd.val;
`ifdef NOTCH2_SATURATE_EN
                sat_d      = sat_q | rnd.sat;
`endif
                state_d    = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
            x0_d    = '0;
            x1_d    = '0;
            x2_d    = '0;
            y1_d    = '0;
            y2_d    = '0;
`ifdef NOTCH2_SATURATE_EN
            sat_d   = 1'b0;
`endif
        end
    end

    // State, history and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tap_q      <= 3'd0;
            x0_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            out_data_q <= '0;
`ifdef NOTCH2_SATURATE_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            out_data_q <= out_data_d;
`ifdef NOTCH2_SATURATE_EN
            sat_q      <= sat_d;
`endif
        end
    end

    // Coefficient bank; writes only land while idle, reset gives passthrough (b0 = 1.0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0_q <= CW'(16384);
            b1_q <= '0;
            b2_q <= '0;
            a1_q <= '0;
            a2_q <= '0;
        end else if (coef_wr) begin
            case (coef_e'(coef_addr))
                B0:      b0_q <= coef_wdata;
                B1:      b1_q <= coef_wdata;
                B2:      b2_q <= coef_wdata;
                A1:      a1_q <= coef_wdata;
                A2:      a2_q <= coef_wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_notch2_biquad_iir.sv
// Scoreboard bench for notch2_biquad_iir: stimulus pushes expected outputs, a monitor pops them.
// Honours NOTCH2_SATURATE_EN for the saturation vector and sat_flag checks.
module tb_notch2_biquad_iir;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        coef_we = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] coef_wdata = '0;
    logic [2:0]  coef_addr = '0;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_data;
`ifdef NOTCH2_SATURATE_EN
    logic        sat_flag;
`endif

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    // Expected outputs of the fs/4 notch with a2 = 0.5 and input +1000, 0, -1000, 0, ...
    int exp3[24] = '{1000, 0, -500, 0, 250, 0, -125, 0, 63, 0, -31, 0,
                     16, 0, -8, 0, 4, 0, -2, 0, 1, 0, 0, 0};

    always #5 clk = ~clk;

    notch2_biquad_iir dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .flush      (flush),
`ifdef NOTCH2_SATURATE_EN
        .sat_flag   (sat_flag),
`endif
        .busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] e, input bit push);
        int n = 0;
        if (push) exp_q.push_back(e);
        in_data  = x;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Monitor: every output handshake must match the oldest expected value
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("out_data", {16'h0, out_data}, {16'h0, mon_exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
`ifdef NOTCH2_SATURATE_EN
        chk("rst_sat_flag", sat_flag, 0);
`endif

        // 1: passthrough defaults and latency
        send(16'd1000, 16'd1000, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("latency_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_valid", out_valid, 1);
        send(16'h8000, 16'h8000, 1);

        // 2: FIR impulse with b0 = b2 = 1.0
        wait_idle();
        flush_pulse();
        wr_coef(3'd2, 16'd16384);
        send(16'd100, 16'd100, 1);
        send(16'd0, 16'd0, 1);
        send(16'd0, 16'd100, 1);

        // 3: fs/4 notch with a2 = 0.5, output decays to zero
        wait_idle();
        flush_pulse();
        wr_coef(3'd4, 16'd8192);
        for (int i = 0; i < 24; i++) begin
            logic [15:0] xv;
            case (i % 4)
                0:       xv = 16'd1000;
                2:       xv = 16'hFC18;
                default: xv = 16'd0;
            endcase
            send(xv, 16'(exp3[i]), 1);
        end

        // 4: overflow, clamped or wrapped depending on build
        wait_idle();
        flush_pulse();
        wr_coef(3'd0, 16'd32767);
        wr_coef(3'd2, 16'd0);
        wr_coef(3'd4, 16'd0);
`ifdef NOTCH2_SATURATE_EN
        send(16'd32767, 16'h7FFF, 1);
        wait_idle();
        chk("sat_flag_set", sat_flag, 1);
        flush_pulse();
        chk("sat_flag_clr", sat_flag, 0);
`else
        send(16'd32767, 16'hFFFC, 1);
`endif

        // 5: backpressure; a coefficient write while busy must be ignored
        wait_idle();
        wr_coef(3'd0, 16'd16384);
        flush_pulse();
        out_ready = 1'b0;
        send(16'd1234, 16'd1234, 1);
        wr_coef(3'd0, 16'd0);
        in_data  = 16'd4321;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            if (out_valid) chk("bp_out_data", out_data, 16'd1234);
        end
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'd4321, 16'd4321, 1);

        // 6: flush during MAC tap 2 aborts and zeroes history
        wait_idle();
        wr_coef(3'd2, 16'd16384);
        send(16'd999, 16'd0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        chk("flush_busy_before", busy, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy_after", busy, 0);
        chk("flush_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("flush_no_valid", out_valid, 0);
        end
        send(16'd50, 16'd50, 1);

        wait_idle();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
